// File: rtl/decode_control_pipe.sv
// decode_control_pipe: single registered RV32 decode stage with a valid/ready
// handshake on both sides, WFI sleep control and a consumed-bundle counter.
module decode_control_pipe #(
    parameter int XLEN     = 32,
    parameter bit EN_M     = 1'b1,
    parameter bit EN_ZICSR = 1'b1,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    input  logic             flush,
    input  logic             irq_pending,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [XLEN-1:0]  out_pc,
    output logic [21:0]      out_ctrl,
    output logic             wfi_sleep,
    output logic [CNT_W-1:0] dec_count
);

    // Field order matches the out_ctrl bit layout, MSB first.
    typedef struct packed {
        logic       illegal;
        logic       m_type;
        logic       is_wfi;
        logic       is_ebreak;
        logic       is_ecall;
        logic       is_mret;
        logic       is_csr;
        logic       csr_to_reg;
        logic       csr_data_sel;
        logic       csr_write;
        logic       r_type;
        logic       jal;
        logic       auipc;
        logic       lui;
        logic [1:0] alu_op;
        logic       jump;
        logic       alu_src;
        logic       branch;
        logic       mem_to_reg;
        logic       mem_write;
        logic       reg_write;
    } ctrl_t;

    typedef enum logic {RUN, SLEEP} state_t;

    localparam logic [1:0] ALU_LS = 2'b00;
    localparam logic [1:0] ALU_I  = 2'b01;
    localparam logic [1:0] ALU_B  = 2'b10;
    localparam logic [1:0] ALU_R  = 2'b11;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    state_t state;
    ctrl_t  dec;
    ctrl_t  ctrl_q;
    logic   bad;
    logic   in_xfer;
    logic   out_xfer;

    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [11:0] funct12;

    assign opcode  = in_instr[6:0];
    assign rd      = in_instr[11:7];
    assign func3   = in_instr[14:12];
    assign rs1     = in_instr[19:15];
    assign funct12 = in_instr[31:20];
    assign funct7  = in_instr[31:25];

    assign in_ready  = !rst && !flush && (state == RUN) && (!out_valid || out_ready);
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;
    assign out_ctrl  = ctrl_q;
    assign wfi_sleep = (state == SLEEP);

    // Combinational decode of the offered instruction; illegal wipes every other bit.
    always_comb begin
        dec = '0;
        bad = 1'b0;
        if (opcode[1:0] != 2'b11) begin
            bad = 1'b1;
        end else begin
            case (opcode)
                OP_R: begin
                    dec.reg_write = 1'b1;
                    dec.alu_op    = ALU_R;
                    dec.r_type    = 1'b1;
                    if (funct7 == 7'h01 && EN_M)
                        dec.m_type = 1'b1;
                    else if (funct7 == 7'h20)
                        bad = !(func3 == 3'd0 || func3 == 3'd5);
                    else if (funct7 != 7'h00)
                        bad = 1'b1;
                end
                OP_I: begin
                    dec.reg_write = 1'b1;
                    dec.alu_src   = 1'b1;
                    dec.alu_op    = ALU_I;
                end
                OP_JALR: begin
                    dec.reg_write = 1'b1;
                    dec.alu_src   = 1'b1;
                    dec.jump      = 1'b1;
                    dec.alu_op    = ALU_LS;
                end
                OP_LOAD: begin
                    dec.reg_write  = 1'b1;
                    dec.mem_to_reg = 1'b1;
                    dec.alu_src    = 1'b1;
                    dec.alu_op     = ALU_LS;
                    bad = (func3 == 3'd3) || (func3 == 3'd6) || (func3 == 3'd7);
                end
                OP_STORE: begin
                    dec.mem_write = 1'b1;
                    dec.alu_src   = 1'b1;
                    dec.alu_op    = ALU_LS;
                    bad = (func3 > 3'd2);
                end
                OP_BRANCH: begin
                    dec.branch = 1'b1;
                    dec.alu_op = ALU_B;
                    bad = (func3 == 3'd2) || (func3 == 3'd3);
                end
                OP_JAL: begin
                    dec.reg_write = 1'b1;
                    dec.jump      = 1'b1;
                    dec.jal       = 1'b1;
                end
                OP_LUI: begin
                    dec.reg_write = 1'b1;
                    dec.alu_src   = 1'b1;
                    dec.lui       = 1'b1;
                end
                OP_AUIPC: begin
                    dec.reg_write = 1'b1;
                    dec.alu_src   = 1'b1;
                    dec.auipc     = 1'b1;
                    dec.csr_write = 1'b0;
                end
                OP_SYSTEM: begin
                    if (func3 == 3'd0) begin
                        // Privileged ops only with rd and rs1 both zero; no write enables.
                        if (rd != 5'd0 || rs1 != 5'd0) begin
                            bad = 1'b1;
                        end else begin
                            case (funct12)
                                12'h000: dec.is_ecall  = 1'b1;
                                12'h001: dec.is_ebreak = 1'b1;
                                12'h302: dec.is_mret   = 1'b1;
                                12'h105: dec.is_wfi    = 1'b1;
                                default: bad = 1'b1;
                            endcase
                        end
                    end else if (func3 == 3'd4 || !EN_ZICSR) begin
                        bad = 1'b1;
                    end else begin
                        dec.is_csr       = 1'b1;
                        dec.reg_write    = 1'b1;
                        dec.csr_to_reg   = 1'b1;
                        dec.csr_data_sel = func3[2];
                        // Set/clear forms with a zero source only read the CSR.
                        dec.csr_write    = !(func3[1] && rs1 == 5'd0);
                    end
                end
                default: bad = 1'b1;
            endcase
        end
        if (bad) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
    end

    // Pipeline register, RUN/SLEEP state and consumed-bundle counter; flush overrides all but the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            out_valid <= 1'b0;
            out_instr <= '0;
            out_pc    <= '0;
            ctrl_q    <= '0;
            dec_count <= '0;
        end else begin
            if (out_xfer)
                dec_count <= dec_count + CNT_W'(1);
            if (flush) begin
                out_valid <= 1'b0;
                state     <= RUN;
            end else begin
                if (out_xfer && ctrl_q.is_wfi)
                    state <= SLEEP;
                else if (state == SLEEP && irq_pending)
                    state <= RUN;
                if (in_xfer) begin
                    out_valid <= 1'b1;
                    out_instr <= in_instr;
                    out_pc    <= in_pc;
                    ctrl_q    <= dec;
                end else if (out_xfer) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_decode_control_pipe.sv
// Bench for decode_control_pipe: two instances (with and without RV32M) share
// stimulus; directed scenarios followed by random traffic against a reference model.
module tb_decode_control_pipe;

    logic        clk = 1'b0;
    logic        rst, in_valid, flush, irq_pending, out_ready;
    logic [31:0] in_instr, in_pc;

    logic        in_ready_m, out_valid_m, wfi_sleep_m;
    logic [31:0] out_instr_m, out_pc_m;
    logic [21:0] out_ctrl_m;
    logic [3:0]  dec_count_m;

    logic        in_ready_n, out_valid_n, wfi_sleep_n;
    logic [31:0] out_instr_n, out_pc_n;
    logic [21:0] out_ctrl_n;
    logic [3:0]  dec_count_n;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit          m_valid, m_sleep;
    logic [31:0] m_instr, m_pc;
    logic [21:0] m_ctrl_m, m_ctrl_n;
    int          m_cnt;

    always #5 clk = ~clk;

    decode_control_pipe #(.XLEN(32), .EN_M(1'b1), .EN_ZICSR(1'b1), .CNT_W(4)) dut_m (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_m),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .irq_pending(irq_pending),
        .out_valid(out_valid_m), .out_ready(out_ready), .out_instr(out_instr_m),
        .out_pc(out_pc_m), .out_ctrl(out_ctrl_m), .wfi_sleep(wfi_sleep_m),
        .dec_count(dec_count_m)
    );

    decode_control_pipe #(.XLEN(32), .EN_M(1'b0), .EN_ZICSR(1'b1), .CNT_W(4)) dut_n (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_n),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .irq_pending(irq_pending),
        .out_valid(out_valid_n), .out_ready(out_ready), .out_instr(out_instr_n),
        .out_pc(out_pc_n), .out_ctrl(out_ctrl_n), .wfi_sleep(wfi_sleep_n),
        .dec_count(dec_count_n)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Control bundle from the instruction-set rules, bit positions as documented.
    function automatic logic [21:0] ref_ctrl(input logic [31:0] ins, input bit en_m);
        logic [21:0] c;
        bit          bad;
        logic [6:0]  op, f7;
        logic [2:0]  f3;
        logic [4:0]  rd, rs1;
        logic [11:0] f12;
        op = ins[6:0]; rd = ins[11:7]; f3 = ins[14:12]; rs1 = ins[19:15];
        f12 = ins[31:20]; f7 = ins[31:25];
        c = '0;
        bad = 0;
        case (op)
            7'h33: begin
                c[0] = 1'b1; c[7:6] = 2'd3; c[11] = 1'b1;
                if (f7 == 7'h01 && en_m) c[20] = 1'b1;
                else if (!(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)))) bad = 1;
            end
            7'h13: begin c[0] = 1'b1; c[4] = 1'b1; c[7:6] = 2'd1; end
            7'h67: begin c[0] = 1'b1; c[4] = 1'b1; c[5] = 1'b1; end
            7'h03: begin
                c[0] = 1'b1; c[2] = 1'b1; c[4] = 1'b1;
                bad = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
            end
            7'h23: begin c[1] = 1'b1; c[4] = 1'b1; bad = (f3 > 3'd2); end
            7'h63: begin c[3] = 1'b1; c[7:6] = 2'd2; bad = (f3 == 3'd2 || f3 == 3'd3); end
            7'h6F: begin c[0] = 1'b1; c[5] = 1'b1; c[10] = 1'b1; end
            7'h37: begin c[0] = 1'b1; c[4] = 1'b1; c[8] = 1'b1; end
            7'h17: begin c[0] = 1'b1; c[4] = 1'b1; c[9] = 1'b1; end
            7'h73: begin
                if (f3 == 3'd0) begin
                    if (rd != 0 || rs1 != 0) bad = 1;
                    else if (f12 == 12'h000) c[17] = 1'b1;
                    else if (f12 == 12'h001) c[18] = 1'b1;
                    else if (f12 == 12'h302) c[16] = 1'b1;
                    else if (f12 == 12'h105) c[19] = 1'b1;
                    else bad = 1;
                end else if (f3 == 3'd4) begin
                    bad = 1;
                end else begin
                    c[15] = 1'b1; c[0] = 1'b1; c[14] = 1'b1;
                    c[13] = (f3 >= 3'd5);
                    c[12] = !((f3 == 3'd2 || f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) && rs1 == 0);
                end
            end
            default: bad = 1;
        endcase
        if (bad) c = 22'h200000;
        return c;
    endfunction

    // One clock: check in_ready mid-cycle, advance the model, check outputs after the edge.
    task automatic cycle();
        bit exp_ready, oxfer, rst_now;
        @(negedge clk);
        exp_ready = !rst && !flush && !m_sleep && (!m_valid || out_ready);
        chk("in_ready_m", 64'(in_ready_m), 64'(exp_ready));
        chk("in_ready_n", 64'(in_ready_n), 64'(exp_ready));
        rst_now = rst;
        if (rst) begin
            m_valid = 0; m_sleep = 0; m_cnt = 0;
            m_instr = '0; m_pc = '0; m_ctrl_m = '0; m_ctrl_n = '0;
        end else begin
            oxfer = m_valid && out_ready;
            if (oxfer) m_cnt = (m_cnt + 1) % 16;
            if (flush) begin
                m_valid = 0; m_sleep = 0;
            end else begin
                if (oxfer && m_ctrl_m[19]) m_sleep = 1;
                else if (m_sleep && irq_pending) m_sleep = 0;
                if (in_valid && exp_ready) begin
                    m_valid = 1; m_instr = in_instr; m_pc = in_pc;
                    m_ctrl_m = ref_ctrl(in_instr, 1'b1);
                    m_ctrl_n = ref_ctrl(in_instr, 1'b0);
                end else if (oxfer) begin
                    m_valid = 0;
                end
            end
        end
        @(posedge clk);
        #1;
        chk("out_valid_m", 64'(out_valid_m), 64'(m_valid));
        chk("out_valid_n", 64'(out_valid_n), 64'(m_valid));
        chk("wfi_sleep_m", 64'(wfi_sleep_m), 64'(m_sleep));
        chk("wfi_sleep_n", 64'(wfi_sleep_n), 64'(m_sleep));
        chk("dec_count_m", 64'(dec_count_m), 64'(m_cnt));
        chk("dec_count_n", 64'(dec_count_n), 64'(m_cnt));
        if (m_valid || rst_now) begin
            chk("out_instr_m", 64'(out_instr_m), 64'(m_instr));
            chk("out_pc_m", 64'(out_pc_m), 64'(m_pc));
            chk("out_ctrl_m", 64'(out_ctrl_m), 64'(m_ctrl_m));
            chk("out_instr_n", 64'(out_instr_n), 64'(m_instr));
            chk("out_pc_n", 64'(out_pc_n), 64'(m_pc));
            chk("out_ctrl_n", 64'(out_ctrl_n), 64'(m_ctrl_n));
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [6:0]  ops [11];
        int          k;
        ops = '{7'h33, 7'h13, 7'h67, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h73, 7'h73};
        r = $urandom;
        k = $urandom_range(0, 12);
        if (k < 11) r[6:0] = ops[k];
        if (k == 0) begin
            case ($urandom_range(0, 3))
                0: r[31:25] = 7'h00;
                1: r[31:25] = 7'h20;
                2: r[31:25] = 7'h01;
                default: ;
            endcase
        end
        if (k == 9 && $urandom_range(0, 1) == 1) r[19:15] = 5'd0;
        if (k == 10) begin
            r[14:12] = 3'd0;
            if ($urandom_range(0, 3) != 0) begin
                r[11:7] = 5'd0; r[19:15] = 5'd0;
                case ($urandom_range(0, 4))
                    0: r[31:20] = 12'h000;
                    1: r[31:20] = 12'h001;
                    2: r[31:20] = 12'h302;
                    3: r[31:20] = 12'h105;
                    default: ;
                endcase
            end
        end
        return r;
    endfunction

    initial begin
        int guard;
        rst = 1; in_valid = 1; flush = 0; irq_pending = 0; out_ready = 1;
        in_instr = 32'h003100B3; in_pc = 32'h0;
        m_valid = 0; m_sleep = 0; m_cnt = 0;
        m_instr = '0; m_pc = '0; m_ctrl_m = '0; m_ctrl_n = '0;

        // reset state
        cycle();
        cycle();
        chk("rst_ctrl", 64'(out_ctrl_m), 64'h0);
        chk("rst_valid", 64'(out_valid_m), 64'h0);
        rst = 0;

        // ADD x1,x2,x3
        in_valid = 1; in_instr = 32'h003100B3; in_pc = 32'h100;
        cycle();
        chk("add_ctrl", 64'(out_ctrl_m), 64'h0008C1);
        chk("add_valid", 64'(out_valid_m), 64'h1);
        in_valid = 0;
        cycle();
        chk("add_count", 64'(dec_count_m), 64'h1);

        // CSRRS x5,mstatus,x0 then CSRRW x0,mtvec,x1
        in_valid = 1; in_instr = 32'h300022F3; in_pc = 32'h104;
        cycle();
        chk("csrrs_is_csr", 64'(out_ctrl_m[15]), 64'h1);
        chk("csrrs_reg_write", 64'(out_ctrl_m[0]), 64'h1);
        chk("csrrs_csr_write", 64'(out_ctrl_m[12]), 64'h0);
        in_instr = 32'h30509073; in_pc = 32'h108;
        cycle();
        chk("csrrw_csr_write", 64'(out_ctrl_m[12]), 64'h1);

        // MUL with and without RV32M
        in_instr = 32'h02208033; in_pc = 32'h10C;
        cycle();
        chk("mul_nom_ctrl", 64'(out_ctrl_n), 64'h200000);
        chk("mul_m_type", 64'(out_ctrl_m[20]), 64'h1);
        chk("mul_m_illegal", 64'(out_ctrl_m[21]), 64'h0);
        in_valid = 0;
        cycle();

        // WFI consumed -> sleep until irq_pending
        in_valid = 1; in_instr = 32'h10500073; in_pc = 32'h110;
        cycle();
        in_valid = 0;
        cycle();
        chk("wfi_sleep", 64'(wfi_sleep_m), 64'h1);
        in_valid = 1; in_instr = 32'h00000013; in_pc = 32'h114;
        cycle();
        cycle();
        chk("wfi_held_off", 64'(out_valid_m), 64'h0);
        irq_pending = 1;
        cycle();
        chk("wfi_wake", 64'(wfi_sleep_m), 64'h0);
        irq_pending = 0;
        in_valid = 0;
        cycle();
        cycle();

        // backpressure for 3 cycles, then flush
        out_ready = 0; in_valid = 1; in_instr = 32'h003100B3; in_pc = 32'h200;
        cycle();
        for (int i = 0; i < 3; i++) begin
            in_instr = $urandom; in_pc = $urandom;
            cycle();
            chk("stall_ctrl", 64'(out_ctrl_m), 64'h0008C1);
            chk("stall_pc", 64'(out_pc_m), 64'h200);
            chk("stall_valid", 64'(out_valid_m), 64'h1);
        end
        flush = 1;
        cycle();
        chk("flush_valid", 64'(out_valid_m), 64'h0);
        flush = 0;

        // reset while a bundle is held, first acceptance right after release
        in_instr = 32'h00500093; in_pc = 32'h300;
        cycle();
        rst = 1;
        cycle();
        chk("mid_rst_valid", 64'(out_valid_m), 64'h0);
        chk("mid_rst_pc", 64'(out_pc_m), 64'h0);
        rst = 0;
        cycle();
        chk("post_rst_accept", 64'(out_valid_m), 64'h1);

        // counter wrap at CNT_W=4
        out_ready = 1; in_valid = 1; in_instr = 32'h00000013;
        guard = 0;
        while (m_cnt != 15 && guard < 40) begin
            cycle();
            guard++;
        end
        chk("wrap_reach", 64'(m_cnt), 64'd15);
        cycle();
        chk("wrap_zero", 64'(dec_count_m), 64'h0);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            flush = ($urandom_range(0, 15) == 0);
            irq_pending = ($urandom_range(0, 3) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_instr = rand_instr();
            in_pc = $urandom;
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
